// File: rtl/bus_fifo_device_pkg.sv
// ============================================================================
// Module      : bus_fifo_device_pkg
// Description : Shared definitions for bus_fifo_device: register offsets,
//               STATUS/CONTROL bit positions and the bus FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package bus_fifo_device_pkg;

    // Register select, taken from address offset bits [3:2]
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;

    // Size of the decoded window in bytes
    localparam logic [31:0] WINDOW_BYTES = 32'd12;

    // STATUS bit positions
    localparam int ST_RX_EMPTY     = 0;
    localparam int ST_RX_FULL      = 1;
    localparam int ST_TX_EMPTY     = 2;
    localparam int ST_TX_FULL      = 3;
    localparam int ST_OVERFLOW     = 4;
    localparam int ST_UNDERFLOW    = 5;
    localparam int ST_RX_COUNT_LSB = 8;
    localparam int ST_TX_COUNT_LSB = 16;

    // CONTROL bit positions
    localparam int CTL_FLUSH_RX    = 0;
    localparam int CTL_FLUSH_TX    = 1;
    localparam int CTL_CLEAR_FLAGS = 2;

    // Bus handshake FSM
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } bus_state_e;

endpackage

`default_nettype wire

// File: rtl/bus_fifo_device_sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with push/pop/flush, occupancy count and
//               full/empty flags. Push when full and pop when empty are
//               ignored; flush overrides any concurrent push or pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [DATA_W-1:0]        head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    // Occupancy at cycle start decides acceptance: no push-through, no pop-through
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Storage array; a flushed push never lands
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and count bookkeeping; power-of-2 depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_fifo_device.sv
// ============================================================================
// Module      : bus_fifo_device
// Description : Memory-mapped bus responder exposing a TX FIFO (bus writes to
//               DATA feed the TX stream) and an RX FIFO (RX stream feeds bus
//               reads of DATA), plus STATUS and CONTROL registers.
//               Optional macro BUS_FIFO_DEVICE_NONBLOCK_EN: accesses to a full
//               TX / empty RX complete at once and set sticky flags instead of
//               stalling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module bus_fifo_device
    import bus_fifo_device_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    parameter int          DEPTH     = 16,
    parameter int          DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       address,
    input  logic [31:0]       data_write,
    input  logic [3:0]        write_mask,
    input  logic              ren,
    input  logic              wen,
    output logic              ready,
    output logic [31:0]       data_read,
    output logic              device_active,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    bus_state_e        state_q;
    logic              ready_q;
    logic [31:0]       data_read_q;

    logic [31:0]       offset;
    logic [1:0]        reg_sel;
    logic              is_wr, is_rd, req, can_go, go;
    logic              sel_data, sel_ctrl;
    logic              tx_push, tx_pop, tx_full, tx_empty, flush_tx;
    logic              rx_push, rx_pop, rx_full, rx_empty, flush_rx;
    logic              ctrl_wr, clear_flags;
    logic              overflow_flag, underflow_flag;
    logic [CW-1:0]     tx_count, rx_count;
    logic [DATA_W-1:0] rx_head;
    logic [31:0]       status_word, rd_value;
    logic              unused_bits;

    // Window decode: below-base addresses wrap to huge offsets and fall out
    assign offset        = address - BASE_ADDR;
    assign device_active = (offset < WINDOW_BYTES);
    assign reg_sel       = offset[3:2];
    assign sel_data      = (reg_sel == REG_DATA);
    assign sel_ctrl      = (reg_sel == REG_CONTROL);
    assign unused_bits   = ^{offset[31:4], offset[1:0], data_write, write_mask[3:1]};

    // Simultaneous ren/wen is treated as a pure write
    assign is_wr = wen;
    assign is_rd = ren && !wen;
    assign req   = (ren || wen) && device_active && (state_q == S_IDLE);

`ifdef BUS_FIFO_DEVICE_NONBLOCK_EN
    assign can_go = 1'b1;
`else
    assign can_go = !(is_wr && sel_data && write_mask[0] && tx_full) &&
                    !(is_rd && sel_data && rx_empty);
`endif
    assign go = req && can_go;

    assign tx_push     = go && is_wr && sel_data && write_mask[0];
    assign rx_pop      = go && is_rd && sel_data;
    assign ctrl_wr     = go && is_wr && sel_ctrl && write_mask[0];
    assign flush_rx    = ctrl_wr && data_write[CTL_FLUSH_RX];
    assign flush_tx    = ctrl_wr && data_write[CTL_FLUSH_TX];
    assign clear_flags = ctrl_wr && data_write[CTL_CLEAR_FLAGS];

    assign tx_pop   = tx_valid && tx_ready;
    assign rx_push  = rx_valid && rx_ready;
    assign tx_valid = !tx_empty;
    assign rx_ready = !rst && !rx_full;

    sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (tx_push),
        .push_data_i(data_write[DATA_W-1:0]),
        .pop_i      (tx_pop),
        .flush_i    (flush_tx),
        .head_o     (tx_data),
        .count_o    (tx_count),
        .full_o     (tx_full),
        .empty_o    (tx_empty)
    );

    sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (rx_push),
        .push_data_i(rx_data),
        .pop_i      (rx_pop),
        .flush_i    (flush_rx),
        .head_o     (rx_head),
        .count_o    (rx_count),
        .full_o     (rx_full),
        .empty_o    (rx_empty)
    );

`ifdef BUS_FIFO_DEVICE_NONBLOCK_EN
    logic overflow_q, underflow_q;

    // Sticky error flags: set by a dropped write or an empty read, cleared by CONTROL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear_flags) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (tx_push && tx_full) begin
                overflow_q <= 1'b1;
            end
            if (rx_pop && rx_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow_flag  = overflow_q;
    assign underflow_flag = underflow_q;
`else
    assign overflow_flag  = 1'b0;
    assign underflow_flag = 1'b0;
`endif

    // Read-data mux; an empty RX yields zero
    always_comb begin
        status_word = '0;
        status_word[ST_RX_EMPTY]  = rx_empty;
        status_word[ST_RX_FULL]   = rx_full;
        status_word[ST_TX_EMPTY]  = tx_empty;
        status_word[ST_TX_FULL]   = tx_full;
        status_word[ST_OVERFLOW]  = overflow_flag;
        status_word[ST_UNDERFLOW] = underflow_flag;
        status_word[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);
        status_word[ST_TX_COUNT_LSB +: 8] = 8'(tx_count);
        rd_value = '0;
        case (reg_sel)
            REG_DATA:   if (!rx_empty) rd_value[DATA_W-1:0] = rx_head;
            REG_STATUS: rd_value = status_word;
            default:    rd_value = '0;
        endcase
    end

    // Handshake FSM: accept in IDLE, pulse ready for the single ACK cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            data_read_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    if (go) begin
                        state_q <= S_ACK;
                        ready_q <= 1'b1;
                        if (is_rd) begin
                            data_read_q <= rd_value;
                        end
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign data_read = data_read_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_fifo_device.sv
// ============================================================================
// Module      : tb_bus_fifo_device
// Description : Directed self-checking bench for bus_fifo_device. Follows the
//               BUS_FIFO_DEVICE_NONBLOCK_EN macro of the build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bus_fifo_device;

    localparam logic [31:0] BASE = 32'h0000_2000;

    logic        clk, rst;
    logic [31:0] address, data_write, data_read;
    logic [3:0]  write_mask;
    logic        ren, wen, ready, device_active;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;

    int total = 0;
    int bad   = 0;

    bus_fifo_device #(.BASE_ADDR(BASE), .DEPTH(16), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .address(address), .data_write(data_write),
        .write_mask(write_mask), .ren(ren), .wen(wen), .ready(ready),
        .data_read(data_read), .device_active(device_active),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issue one bus request from a negedge; returns cycles until ready (0 = timeout)
    task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input logic rd, input logic wr,
                           output int cyc, output logic [31:0] rdata);
        int n;
        address = addr; data_write = wdata; write_mask = mask; ren = rd; wen = wr;
        n = 0; cyc = 0;
        while (n < 20 && cyc == 0) begin
            @(negedge clk);
            n++;
            if (ready) cyc = n;
        end
        rdata = data_read;
        ren = 1'b0; wen = 1'b0;
    endtask

    task automatic test_reset();
        int cyc; logic [31:0] rd;
        rst = 1'b1; address = 32'h0; data_write = 32'h0; write_mask = 4'h0;
        ren = 1'b0; wen = 1'b0; tx_ready = 1'b0; rx_data = 8'h0; rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        total++; if (data_read !== 32'h0) begin bad++; $display("FAIL reset_data_read: got %h want 0", data_read); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL post_reset_rx_ready: got %b want 1", rx_ready); end
        do_xfer(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0000_0005) begin bad++; $display("FAIL reset_status: got %h want 00000005", rd); end
        @(negedge clk);
    endtask

    task automatic test_tx_write();
        int cyc; logic [31:0] rd;
        do_xfer(BASE, 32'h0000_0041, 4'b0001, 1'b0, 1'b1, cyc, rd);
        total++; if (cyc !== 1) begin bad++; $display("FAIL tx_write_latency: got %0d want 1", cyc); end
        @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL ready_one_cycle: got %b want 0", ready); end
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL tx_valid: got %b want 1", tx_valid); end
        total++; if (tx_data !== 8'h41) begin bad++; $display("FAIL tx_data: got %h want 41", tx_data); end
        do_xfer(BASE, 32'h0000_0099, 4'b1110, 1'b0, 1'b1, cyc, rd);
        do_xfer(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0001_0001) begin bad++; $display("FAIL tx_status: got %h want 00010001", rd); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_drain: got %b want 0", tx_valid); end
    endtask

    task automatic test_rx_read();
        int cyc; logic [31:0] rd;
        rx_data = 8'h5A; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        do_xfer(BASE, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0000_005A) begin bad++; $display("FAIL rx_read_data: got %h want 0000005a", rd); end
        do_xfer(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0000_0005) begin bad++; $display("FAIL rx_status_empty: got %h want 00000005", rd); end
        // ren and wen together: write side only
        @(negedge clk);
        rx_data = 8'h33; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        do_xfer(BASE, 32'h0000_0077, 4'b0001, 1'b1, 1'b1, cyc, rd);
        do_xfer(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0001_0100) begin bad++; $display("FAIL rw_both_status: got %h want 00010100", rd); end
        total++; if (tx_data !== 8'h77) begin bad++; $display("FAIL rw_both_tx_data: got %h want 77", tx_data); end
        do_xfer(BASE, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0000_0033) begin bad++; $display("FAIL rw_both_rx_kept: got %h want 00000033", rd); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc; logic [31:0] rd; bit seen;
        for (int i = 0; i < 16; i++) begin
            do_xfer(BASE, 32'h10 + 32'(i), 4'b0001, 1'b0, 1'b1, cyc, rd);
            total++;
            if (cyc !== ((i == 0) ? 1 : 2)) begin
                bad++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, cyc, (i == 0) ? 1 : 2);
            end
        end
        do_xfer(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0010_0009) begin bad++; $display("FAIL tx_full_status: got %h want 00100009", rd); end
`ifdef BUS_FIFO_DEVICE_NONBLOCK_EN
        do_xfer(BASE, 32'h2F, 4'b0001, 1'b0, 1'b1, cyc, rd);
        total++; if (cyc !== 2) begin bad++; $display("FAIL overflow_latency: got %0d want 2", cyc); end
        do_xfer(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0010_0019) begin bad++; $display("FAIL overflow_status: got %h want 00100019", rd); end
        do_xfer(BASE + 32'h8, 32'h4, 4'b0001, 1'b0, 1'b1, cyc, rd);
        do_xfer(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0010_0009) begin bad++; $display("FAIL overflow_clear: got %h want 00100009", rd); end
`else
        address = BASE; data_write = 32'h2F; write_mask = 4'b0001; wen = 1'b1;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (ready) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL full_stall: got ready 1 want 0"); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin @(negedge clk); if (ready) seen = 1'b1; end
        wen = 1'b0;
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL stall_release: got ready 0 want 1"); end
        total++; if (tx_data !== 8'h11) begin bad++; $display("FAIL tx_order: got %h want 11", tx_data); end
        do_xfer(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0010_0009) begin bad++; $display("FAIL refill_status: got %h want 00100009", rd); end
`endif
        do_xfer(BASE + 32'h8, 32'h2, 4'b0001, 1'b0, 1'b1, cyc, rd);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL flush_tx_only: got %b want 0", tx_valid); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int cyc; logic [31:0] rd;
        rx_data = 8'hA0; rx_valid = 1'b1;
        repeat (8) @(negedge clk);
        rx_valid = 1'b0;
        do_xfer(BASE, 32'h1, 4'b0001, 1'b0, 1'b1, cyc, rd);
        do_xfer(BASE, 32'h2, 4'b0001, 1'b0, 1'b1, cyc, rd);
        do_xfer(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0002_0800) begin bad++; $display("FAIL half_full_status: got %h want 00020800", rd); end
        @(negedge clk);
        rx_valid = 1'b1;
        do_xfer(BASE + 32'h8, 32'h3, 4'b0001, 1'b0, 1'b1, cyc, rd);
        rx_valid = 1'b0;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL flush_tx_valid: got %b want 0", tx_valid); end
        do_xfer(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0000_0005) begin bad++; $display("FAIL flush_status: got %h want 00000005", rd); end
        do_xfer(BASE + 32'h8, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL control_read: got %h want 0", rd); end
        @(negedge clk);
    endtask

    task automatic test_addr();
        bit seen;
        address = BASE + 32'hC; #1;
        total++; if (device_active !== 1'b0) begin bad++; $display("FAIL active_above: got %b want 0", device_active); end
        address = BASE - 32'h4; #1;
        total++; if (device_active !== 1'b0) begin bad++; $display("FAIL active_below: got %b want 0", device_active); end
        address = BASE + 32'h8; #1;
        total++; if (device_active !== 1'b1) begin bad++; $display("FAIL active_top: got %b want 1", device_active); end
        address = BASE + 32'hC; data_write = 32'h55; write_mask = 4'b0001; wen = 1'b1;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (ready) seen = 1'b1; end
        wen = 1'b0;
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL outside_ready: got ready 1 want 0"); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL outside_push: got %b want 0", tx_valid); end
    endtask

`ifdef BUS_FIFO_DEVICE_NONBLOCK_EN
    task automatic test_underflow();
        int cyc; logic [31:0] rd;
        @(negedge clk);
        do_xfer(BASE, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (cyc !== 1) begin bad++; $display("FAIL underflow_latency: got %0d want 1", cyc); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL underflow_data: got %h want 0", rd); end
        do_xfer(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0000_0025) begin bad++; $display("FAIL underflow_status: got %h want 00000025", rd); end
        do_xfer(BASE + 32'h8, 32'h4, 4'b0001, 1'b0, 1'b1, cyc, rd);
        do_xfer(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0000_0005) begin bad++; $display("FAIL underflow_clear: got %h want 00000005", rd); end
    endtask
`endif

    task automatic test_reset_mid();
        int cyc; logic [31:0] rd; bit seen;
        @(negedge clk);
        address = BASE; ren = 1'b1;
        seen = 1'b0;
`ifndef BUS_FIFO_DEVICE_NONBLOCK_EN
        repeat (3) begin @(negedge clk); if (ready) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL empty_read_stall: got ready 1 want 0"); end
`endif
        rst = 1'b1;
        repeat (3) begin @(negedge clk); if (ready) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid_ready: got ready 1 want 0"); end
        ren = 1'b0; rst = 1'b0;
        @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_mid_after: got %b want 0", ready); end
        do_xfer(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, cyc, rd);
        total++; if (rd !== 32'h0000_0005) begin bad++; $display("FAIL reset_mid_status: got %h want 00000005", rd); end
    endtask

    initial begin
        test_reset();
        test_tx_write();
        test_rx_read();
        test_back_to_back();
        test_flush();
        test_addr();
`ifdef BUS_FIFO_DEVICE_NONBLOCK_EN
        test_underflow();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
